hemaia_mem_superbank_arbiter: RTL and testbench

//  Per-superbank arbiter between one wide (AXI-side) memory port and BanksPerSuperBank narrow
//  (XDMA-side) bank ports, driving BanksPerSuperBank 64-bit SRAM banks of fixed read latency.

---
 rtl/hemaia_mem_superbank_arbiter.sv | 129 ++++++++++++
 tb/tb_hemaia_mem_superbank_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hemaia_mem_superbank_arbiter.sv
// Superbank arbiter: one wide port against per-bank narrow ports onto B 64-bit SRAM banks.
// Fair mode bounds narrow starvation; the wide port owns the slot right after a forced narrow cycle.
module hemaia_mem_superbank_arbiter #(
  parameter int BanksPerSuperBank = 4,
  parameter int MemAddrWidth      = 10,
  parameter int MemLatency        = 1,
  parameter int ArbMode           = 1,
  parameter int StarveLimit       = 8
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic                                    wide_q_valid_i,
  output logic                                    wide_q_ready_o,
  input  logic [MemAddrWidth-1:0]                 wide_q_addr_i,
  input  logic                                    wide_q_write_i,
  input  logic [64*BanksPerSuperBank-1:0]         wide_q_data_i,
  input  logic [8*BanksPerSuperBank-1:0]          wide_q_strb_i,
  output logic                                    wide_p_valid_o,
  output logic [64*BanksPerSuperBank-1:0]         wide_p_data_o,
  input  logic [BanksPerSuperBank-1:0]            nar_q_valid_i,
  output logic [BanksPerSuperBank-1:0]            nar_q_ready_o,
  input  logic [BanksPerSuperBank*MemAddrWidth-1:0] nar_q_addr_i,
  input  logic [BanksPerSuperBank-1:0]            nar_q_write_i,
  input  logic [BanksPerSuperBank*64-1:0]         nar_q_data_i,
  input  logic [BanksPerSuperBank*8-1:0]          nar_q_strb_i,
  output logic [BanksPerSuperBank-1:0]            nar_p_valid_o,
  output logic [BanksPerSuperBank*64-1:0]         nar_p_data_o,
  output logic [BanksPerSuperBank-1:0]            mem_cs_o,
  output logic [BanksPerSuperBank-1:0]            mem_wen_o,
  output logic [BanksPerSuperBank*MemAddrWidth-1:0] mem_add_o,
  output logic [BanksPerSuperBank*8-1:0]          mem_be_o,
  output logic [BanksPerSuperBank*64-1:0]         mem_wdata_o,
  input  logic [BanksPerSuperBank*64-1:0]         mem_rdata_i,
  output logic [31:0]                             wide_stall_cnt_o
);
  localparam int B  = BanksPerSuperBank;
  localparam int AW = MemAddrWidth;
  localparam int SW = $clog2(StarveLimit + 1);

  logic [SW-1:0] starve_cnt [B];
  logic [B-1:0]  at_limit;
  logic          wide_owed;
  logic          force_nar;
  logic          wide_gnt;
  logic [B-1:0]  nar_gnt;
  logic [B:0]    rsp_in;
  logic [B:0]    rsp_pipe [MemLatency];

  always_comb begin
    at_limit = '0;
    for (int j = 0; j < B; j++) at_limit[j] = (starve_cnt[j] == SW'(StarveLimit));
  end

  // Owed wide access beats a pending force so the wide port cannot be starved in turn.
  always_comb begin
    wide_gnt  = 1'b0;
    nar_gnt   = '0;
    force_nar = 1'b0;
    if (!rst_i) begin
      if (ArbMode != 0 && wide_owed && wide_q_valid_i) begin
        wide_gnt = 1'b1;
      end else if (ArbMode != 0 && (|at_limit) && !wide_owed) begin
        force_nar = 1'b1;
        nar_gnt   = nar_q_valid_i;
      end else begin
        wide_gnt = wide_q_valid_i;
        nar_gnt  = nar_q_valid_i & ~{B{wide_q_valid_i}};
      end
    end
  end

  assign wide_q_ready_o = wide_gnt;
  assign nar_q_ready_o  = nar_gnt;

  always_comb begin
    mem_cs_o    = '0;
    mem_wen_o   = '0;
    mem_add_o   = '0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    for (int j = 0; j < B; j++) begin
      if (wide_gnt) begin
        mem_cs_o[j]              = 1'b1;
        mem_wen_o[j]             = wide_q_write_i;
        mem_add_o[j*AW +: AW]    = wide_q_addr_i;
        mem_be_o[j*8 +: 8]       = wide_q_strb_i[j*8 +: 8];
        mem_wdata_o[j*64 +: 64]  = wide_q_data_i[j*64 +: 64];
      end else if (nar_gnt[j]) begin
        mem_cs_o[j]              = 1'b1;
        mem_wen_o[j]             = nar_q_write_i[j];
        mem_add_o[j*AW +: AW]    = nar_q_addr_i[j*AW +: AW];
        mem_be_o[j*8 +: 8]       = nar_q_strb_i[j*8 +: 8];
        mem_wdata_o[j*64 +: 64]  = nar_q_data_i[j*64 +: 64];
      end
    end
  end

  assign rsp_in = {wide_gnt & ~wide_q_write_i, nar_gnt & ~nar_q_write_i};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int j = 0; j < B; j++) starve_cnt[j] <= '0;
      for (int i = 0; i < MemLatency; i++) rsp_pipe[i] <= '0;
      wide_owed        <= 1'b0;
      wide_stall_cnt_o <= '0;
    end else begin
      for (int j = 0; j < B; j++) begin
        if (nar_q_valid_i[j] && !nar_gnt[j])
          starve_cnt[j] <= at_limit[j] ? starve_cnt[j] : starve_cnt[j] + SW'(1);
        else
          starve_cnt[j] <= '0;
      end
      if (force_nar)
        wide_owed <= 1'b1;
      else if (wide_owed && (wide_gnt || !wide_q_valid_i))
        wide_owed <= 1'b0;
      if (wide_q_valid_i && !wide_gnt && wide_stall_cnt_o != '1)
        wide_stall_cnt_o <= wide_stall_cnt_o + 32'd1;
      rsp_pipe[0] <= rsp_in;
      for (int i = 1; i < MemLatency; i++) rsp_pipe[i] <= rsp_pipe[i-1];
    end
  end

  assign wide_p_valid_o = rsp_pipe[MemLatency-1][B];
  assign nar_p_valid_o  = rsp_pipe[MemLatency-1][B-1:0];
  assign wide_p_data_o  = mem_rdata_i;
  assign nar_p_data_o   = mem_rdata_i;

endmodule

// File: tb/tb_hemaia_mem_superbank_arbiter.sv
// Bench for the superbank arbiter: a fair-mode instance (latency 2, limit 3) and a
// wide-priority instance (latency 3) share stimulus and are compared against a cycle model.
module tb_hemaia_mem_superbank_arbiter;
  localparam int B  = 4;
  localparam int AW = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              wide_q_valid, wide_q_write;
  logic [AW-1:0]     wide_q_addr;
  logic [64*B-1:0]   wide_q_data;
  logic [8*B-1:0]    wide_q_strb;
  logic [B-1:0]      nar_q_valid, nar_q_write;
  logic [B*AW-1:0]   nar_q_addr;
  logic [B*64-1:0]   nar_q_data;
  logic [B*8-1:0]    nar_q_strb;
  logic [B*64-1:0]   mem_rdata;

  logic [1:0]             wide_q_ready, wide_p_valid;
  logic [1:0][64*B-1:0]   wide_p_data;
  logic [1:0][B-1:0]      nar_q_ready, nar_p_valid, mem_cs, mem_wen;
  logic [1:0][B*64-1:0]   nar_p_data, mem_wdata;
  logic [1:0][B*AW-1:0]   mem_add;
  logic [1:0][B*8-1:0]    mem_be;
  logic [1:0][31:0]       stall_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  hemaia_mem_superbank_arbiter #(.BanksPerSuperBank(B), .MemAddrWidth(AW), .MemLatency(3),
    .ArbMode(0), .StarveLimit(8)) dut0 (
    .clk_i(clk), .rst_i(rst), .wide_q_valid_i(wide_q_valid), .wide_q_ready_o(wide_q_ready[0]),
    .wide_q_addr_i(wide_q_addr), .wide_q_write_i(wide_q_write), .wide_q_data_i(wide_q_data),
    .wide_q_strb_i(wide_q_strb), .wide_p_valid_o(wide_p_valid[0]), .wide_p_data_o(wide_p_data[0]),
    .nar_q_valid_i(nar_q_valid), .nar_q_ready_o(nar_q_ready[0]), .nar_q_addr_i(nar_q_addr),
    .nar_q_write_i(nar_q_write), .nar_q_data_i(nar_q_data), .nar_q_strb_i(nar_q_strb),
    .nar_p_valid_o(nar_p_valid[0]), .nar_p_data_o(nar_p_data[0]), .mem_cs_o(mem_cs[0]),
    .mem_wen_o(mem_wen[0]), .mem_add_o(mem_add[0]), .mem_be_o(mem_be[0]),
    .mem_wdata_o(mem_wdata[0]), .mem_rdata_i(mem_rdata), .wide_stall_cnt_o(stall_cnt[0]));

  hemaia_mem_superbank_arbiter #(.BanksPerSuperBank(B), .MemAddrWidth(AW), .MemLatency(2),
    .ArbMode(1), .StarveLimit(3)) dut1 (
    .clk_i(clk), .rst_i(rst), .wide_q_valid_i(wide_q_valid), .wide_q_ready_o(wide_q_ready[1]),
    .wide_q_addr_i(wide_q_addr), .wide_q_write_i(wide_q_write), .wide_q_data_i(wide_q_data),
    .wide_q_strb_i(wide_q_strb), .wide_p_valid_o(wide_p_valid[1]), .wide_p_data_o(wide_p_data[1]),
    .nar_q_valid_i(nar_q_valid), .nar_q_ready_o(nar_q_ready[1]), .nar_q_addr_i(nar_q_addr),
    .nar_q_write_i(nar_q_write), .nar_q_data_i(nar_q_data), .nar_q_strb_i(nar_q_strb),
    .nar_p_valid_o(nar_p_valid[1]), .nar_p_data_o(nar_p_data[1]), .mem_cs_o(mem_cs[1]),
    .mem_wen_o(mem_wen[1]), .mem_add_o(mem_add[1]), .mem_be_o(mem_be[1]),
    .mem_wdata_o(mem_wdata[1]), .mem_rdata_i(mem_rdata), .wide_stall_cnt_o(stall_cnt[1]));

  // ---------------- reference model ----------------
  int         m_starve [2][B];
  logic       m_owed   [2];
  longint     m_stall  [2];
  logic [B:0] m_ring   [2][16];
  int         m_cyc = 0;

  function automatic int lat_of(input int d);
    return (d == 1) ? 2 : 3;
  endfunction

  function automatic int limit_of(input int d);
    return (d == 1) ? 3 : 8;
  endfunction

  function automatic void model_grant(input int d, output logic w, output logic [B-1:0] n,
                                      output logic frc);
    logic starved;
    starved = 1'b0; w = 1'b0; n = '0; frc = 1'b0;
    for (int j = 0; j < B; j++) if (m_starve[d][j] >= limit_of(d)) starved = 1'b1;
    if (!rst) begin
      if (d == 1 && m_owed[d] && wide_q_valid) begin
        w = 1'b1;
      end else if (d == 1 && starved && !m_owed[d]) begin
        n = nar_q_valid; frc = 1'b1;
      end else begin
        w = wide_q_valid;
        n = wide_q_valid ? '0 : nar_q_valid;
      end
    end
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        for (int j = 0; j < B; j++) m_starve[d][j] <= 0;
        for (int k = 0; k < 16; k++) m_ring[d][k] <= '0;
        m_owed[d]  <= 1'b0;
        m_stall[d] <= 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        automatic logic w;
        automatic logic [B-1:0] n;
        automatic logic frc;
        model_grant(d, w, n, frc);
        for (int j = 0; j < B; j++)
          m_starve[d][j] <= (nar_q_valid[j] && !n[j]) ?
                            ((m_starve[d][j] < limit_of(d)) ? m_starve[d][j] + 1 : m_starve[d][j]) : 0;
        if (frc) m_owed[d] <= 1'b1;
        else if (m_owed[d] && (w || !wide_q_valid)) m_owed[d] <= 1'b0;
        if (wide_q_valid && !w && m_stall[d] < 64'hFFFF_FFFF) m_stall[d] <= m_stall[d] + 1;
        m_ring[d][(m_cyc + lat_of(d)) % 16] <= {w & ~wide_q_write, n & ~nar_q_write};
        m_ring[d][m_cyc % 16] <= '0;
      end
      m_cyc <= m_cyc + 1;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive_idle();
    wide_q_valid = 1'b0; wide_q_write = 1'b0; wide_q_addr = '0;
    wide_q_data = '0; wide_q_strb = '0;
    nar_q_valid = '0; nar_q_write = '0; nar_q_addr = '0; nar_q_data = '0; nar_q_strb = '0;
  endtask

  task automatic rand_stim(input int pw, input int pn);
    wide_q_valid = ($urandom_range(99) < pw);
    wide_q_write = $urandom_range(1);
    wide_q_addr  = AW'($urandom);
    wide_q_strb  = $urandom;
    for (int i = 0; i < 2*B; i++) wide_q_data[32*i +: 32] = $urandom;
    for (int j = 0; j < B; j++) nar_q_valid[j] = ($urandom_range(99) < pn);
    nar_q_write = B'($urandom);
    for (int j = 0; j < B; j++) nar_q_addr[j*AW +: AW] = AW'($urandom);
    nar_q_strb = $urandom;
    for (int i = 0; i < 2*B; i++) nar_q_data[32*i +: 32] = $urandom;
    for (int i = 0; i < 2*B; i++) mem_rdata[32*i +: 32] = $urandom;
  endtask

  task automatic pulse_reset();
    @(negedge clk); drive_idle(); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    rand_stim(100, 100);
    #1;
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if ({wide_q_ready[d], nar_q_ready[d], mem_cs[d], mem_wen[d]} !== '0)
        $display("FAIL reset_grants dut%0d got %b want 0", d, {wide_q_ready[d], nar_q_ready[d], mem_cs[d], mem_wen[d]});
      else n_pass++;
      n_checks++;
      if ({mem_add[d], mem_be[d], mem_wdata[d]} !== '0)
        $display("FAIL reset_mem_bus dut%0d got nonzero want 0", d);
      else n_pass++;
      n_checks++;
      if ({wide_p_valid[d], nar_p_valid[d], stall_cnt[d]} !== '0)
        $display("FAIL reset_pvalid_stall dut%0d got %h want 0", d, {wide_p_valid[d], nar_p_valid[d], stall_cnt[d]});
      else n_pass++;
    end
    @(negedge clk); drive_idle(); rst = 1'b0;
  endtask

  task automatic test_wide_read_latency();
    @(negedge clk);
    drive_idle();
    wide_q_valid = 1'b1; wide_q_addr = 10'h010;
    #1;
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (mem_cs[d] !== 4'hF || mem_wen[d] !== 4'h0 || wide_q_ready[d] !== 1'b1)
        $display("FAIL wide_rd_grant dut%0d got cs=%h wen=%h rdy=%b want cs=f wen=0 rdy=1", d, mem_cs[d], mem_wen[d], wide_q_ready[d]);
      else n_pass++;
      n_checks++;
      if (mem_add[d] !== {4{10'h010}})
        $display("FAIL wide_rd_addr dut%0d got %h want %h", d, mem_add[d], {4{10'h010}});
      else n_pass++;
    end
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      drive_idle();
      for (int i = 0; i < 2*B; i++) mem_rdata[32*i +: 32] = $urandom;
      #1;
      for (int d = 0; d < 2; d++) begin
        n_checks++;
        if (wide_p_valid[d] !== (c == lat_of(d)))
          $display("FAIL wide_rd_pvalid dut%0d cycle %0d got %b want %b", d, c, wide_p_valid[d], c == lat_of(d));
        else n_pass++;
      end
      n_checks++;
      if (wide_p_data[1] !== mem_rdata)
        $display("FAIL wide_rd_pdata got %h want %h", wide_p_data[1], mem_rdata);
      else n_pass++;
    end
  endtask

  task automatic test_starvation();
    pulse_reset();
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      drive_idle();
      wide_q_valid = 1'b1; wide_q_addr = AW'($urandom);
      nar_q_valid = 4'b0010; nar_q_write = 4'b0010;
      #1;
      n_checks++;
      if (nar_q_ready[1][1] !== (k % 4 == 3) || wide_q_ready[1] !== (k % 4 != 3))
        $display("FAIL fair_pattern k=%0d got nar=%b wide=%b want nar=%b wide=%b", k, nar_q_ready[1][1], wide_q_ready[1], k % 4 == 3, k % 4 != 3);
      else n_pass++;
      n_checks++;
      if (nar_q_ready[0] !== 4'b0000 || wide_q_ready[0] !== 1'b1)
        $display("FAIL prio_pattern k=%0d got nar=%b wide=%b want nar=0000 wide=1", k, nar_q_ready[0], wide_q_ready[0]);
      else n_pass++;
    end
    @(negedge clk); drive_idle(); #1;
    n_checks++;
    if (stall_cnt[1] !== 32'd3)
      $display("FAIL fair_stall_cnt got %0d want 3", stall_cnt[1]);
    else n_pass++;
    n_checks++;
    if (stall_cnt[0] !== 32'd0)
      $display("FAIL prio_stall_cnt got %0d want 0", stall_cnt[0]);
    else n_pass++;
  endtask

  task automatic test_narrow_mix();
    @(negedge clk);
    drive_idle();
    nar_q_valid = 4'b1111; nar_q_write = 4'b0101; nar_q_strb = $urandom;
    #1;
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (mem_cs[d] !== 4'hF || mem_wen[d] !== 4'b0101)
        $display("FAIL nar_mix_grant dut%0d got cs=%b wen=%b want cs=1111 wen=0101", d, mem_cs[d], mem_wen[d]);
      else n_pass++;
    end
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk); drive_idle(); #1;
      for (int d = 0; d < 2; d++) begin
        n_checks++;
        if (nar_p_valid[d] !== ((c == lat_of(d)) ? 4'b1010 : 4'b0000))
          $display("FAIL nar_mix_pvalid dut%0d cycle %0d got %b want %b", d, c, nar_p_valid[d], (c == lat_of(d)) ? 4'b1010 : 4'b0000);
        else n_pass++;
      end
    end
  endtask

  task automatic test_wide_write_strb();
    logic [64*B-1:0] wd;
    @(negedge clk);
    drive_idle();
    for (int i = 0; i < 2*B; i++) wd[32*i +: 32] = $urandom;
    wide_q_valid = 1'b1; wide_q_write = 1'b1; wide_q_strb = 32'h0F0F_0F0F; wide_q_data = wd;
    #1;
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (mem_be[d] !== 32'h0F0F_0F0F || mem_wen[d] !== 4'hF)
        $display("FAIL wide_wr_be dut%0d got be=%h wen=%h want be=0f0f0f0f wen=f", d, mem_be[d], mem_wen[d]);
      else n_pass++;
      for (int j = 0; j < B; j++) begin
        n_checks++;
        if (mem_wdata[d][j*64 +: 64] !== wd[j*64 +: 64])
          $display("FAIL wide_wr_slice dut%0d bank%0d got %h want %h", d, j, mem_wdata[d][j*64 +: 64], wd[j*64 +: 64]);
        else n_pass++;
      end
    end
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk); drive_idle(); #1;
      n_checks++;
      if (wide_p_valid !== 2'b00)
        $display("FAIL wide_wr_noresp cycle %0d got %b want 00", c, wide_p_valid);
      else n_pass++;
    end
  endtask

  task automatic test_reset_midread();
    @(negedge clk);
    drive_idle();
    wide_q_valid = 1'b1; wide_q_addr = 10'h3A5;
    #1;
    n_checks++;
    if (wide_q_ready[0] !== 1'b1)
      $display("FAIL midrd_grant got %b want 1", wide_q_ready[0]);
    else n_pass++;
    @(negedge clk); drive_idle(); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); drive_idle(); #1;
      n_checks++;
      if (wide_p_valid !== 2'b00 || stall_cnt[0] !== 32'd0 || stall_cnt[1] !== 32'd0)
        $display("FAIL midrd_dropped cycle %0d got pv=%b stall0=%0d stall1=%0d want 0", c, wide_p_valid, stall_cnt[0], stall_cnt[1]);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      rst = ($urandom_range(199) == 0);
      rand_stim(70, 60);
      #1;
      for (int d = 0; d < 2; d++) begin
        logic w, frc;
        logic [B-1:0] n, e_cs, e_wen;
        logic [B*AW-1:0] e_add;
        logic [B*8-1:0] e_be;
        logic [B*64-1:0] e_wd;
        model_grant(d, w, n, frc);
        e_cs = '0; e_wen = '0; e_add = '0; e_be = '0; e_wd = '0;
        for (int j = 0; j < B; j++) begin
          if (w) begin
            e_cs[j] = 1'b1; e_wen[j] = wide_q_write; e_add[j*AW +: AW] = wide_q_addr;
            e_be[j*8 +: 8] = wide_q_strb[j*8 +: 8]; e_wd[j*64 +: 64] = wide_q_data[j*64 +: 64];
          end else if (n[j]) begin
            e_cs[j] = 1'b1; e_wen[j] = nar_q_write[j]; e_add[j*AW +: AW] = nar_q_addr[j*AW +: AW];
            e_be[j*8 +: 8] = nar_q_strb[j*8 +: 8]; e_wd[j*64 +: 64] = nar_q_data[j*64 +: 64];
          end
        end
        n_checks++;
        if (wide_q_ready[d] !== w || nar_q_ready[d] !== n)
          $display("FAIL rnd_grant dut%0d cyc %0d got w=%b n=%b want w=%b n=%b", d, cyc, wide_q_ready[d], nar_q_ready[d], w, n);
        else n_pass++;
        n_checks++;
        if (mem_cs[d] !== e_cs || mem_wen[d] !== e_wen || mem_add[d] !== e_add)
          $display("FAIL rnd_ctrl dut%0d cyc %0d got cs=%b wen=%b add=%h want cs=%b wen=%b add=%h", d, cyc, mem_cs[d], mem_wen[d], mem_add[d], e_cs, e_wen, e_add);
        else n_pass++;
        n_checks++;
        if (mem_be[d] !== e_be || mem_wdata[d] !== e_wd)
          $display("FAIL rnd_wdata dut%0d cyc %0d got be=%h want be=%h", d, cyc, mem_be[d], e_be);
        else n_pass++;
        n_checks++;
        if ({wide_p_valid[d], nar_p_valid[d]} !== m_ring[d][m_cyc % 16])
          $display("FAIL rnd_pvalid dut%0d cyc %0d got %b want %b", d, cyc, {wide_p_valid[d], nar_p_valid[d]}, m_ring[d][m_cyc % 16]);
        else n_pass++;
        n_checks++;
        if (stall_cnt[d] !== 32'(m_stall[d]))
          $display("FAIL rnd_stall dut%0d cyc %0d got %0d want %0d", d, cyc, stall_cnt[d], m_stall[d]);
        else n_pass++;
        n_checks++;
        if (nar_p_data[d] !== mem_rdata || wide_p_data[d] !== mem_rdata)
          $display("FAIL rnd_pdata dut%0d cyc %0d got %h want %h", d, cyc, nar_p_data[d], mem_rdata);
        else n_pass++;
      end
    end
    @(negedge clk); drive_idle(); rst = 1'b0;
  endtask

  initial begin
    drive_idle();
    mem_rdata = '0;
    test_reset();
    test_wide_read_latency();
    test_starvation();
    test_narrow_mix();
    test_wide_write_strb();
    test_reset_midread();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit expired with %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
